// File: rtl/instr_reg_sequencer.sv
// rtl/instr_reg_sequencer.sv - arbitrating write sequencer and read port for the 32-entry instruction register
package instr_reg_sequencer_pkg;
    localparam int IRS_OPW = 4;
    localparam int IRS_DW  = 32;

    typedef struct packed {
        logic [IRS_OPW-1:0]       opcode;
        logic signed [IRS_DW-1:0] operand_a;
        logic signed [IRS_DW-1:0] operand_b;
    } instruction_t;
endpackage

module instr_reg_sequencer
    import instr_reg_sequencer_pkg::instruction_t;
#(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int OPW   = 4,
    parameter int DW    = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [OPW-1:0]       req0_opcode,
    input  logic signed [DW-1:0] req0_operand_a,
    input  logic signed [DW-1:0] req0_operand_b,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [OPW-1:0]       req1_opcode,
    input  logic signed [DW-1:0] req1_operand_a,
    input  logic signed [DW-1:0] req1_operand_b,
    output logic                 load_en,
    output logic [OPW-1:0]       opcode,
    output logic signed [DW-1:0] operand_a,
    output logic signed [DW-1:0] operand_b,
    output logic [AW-1:0]        write_pointer,
    output logic [AW-1:0]        read_pointer,
    input  instruction_t         instruction_word,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output instruction_t         rd_word,
    output logic [AW:0]          count,
    output logic                 full,
    output logic                 empty
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] LOAD = 1'b1;

    logic [0:0] state;
    logic       last_grant;
    logic       grant;
    logic       accept;
    logic       commit;
    logic       rd_fire;

    // With both requesters valid, the one that did not win last time goes next.
    assign grant  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    assign accept = (state == IDLE) && !flush && !full && (req0_valid || req1_valid);

    assign req0_ready = accept && !grant;
    assign req1_ready = accept && grant;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign rd_valid = !empty;
    assign rd_word  = instruction_word;

    assign commit  = (state == LOAD) && !flush;
    assign rd_fire = rd_ready && rd_valid && !flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            load_en       <= 1'b0;
            opcode        <= '0;
            operand_a     <= '0;
            operand_b     <= '0;
            write_pointer <= '0;
            read_pointer  <= '0;
            count         <= '0;
        end else if (flush) begin
            // An in-flight write still lands in the register but is never counted.
            state         <= IDLE;
            load_en       <= 1'b0;
            write_pointer <= '0;
            read_pointer  <= '0;
            count         <= '0;
        end else begin
            if (accept) begin
                state      <= LOAD;
                load_en    <= 1'b1;
                last_grant <= grant;
                opcode     <= grant ? req1_opcode    : req0_opcode;
                operand_a  <= grant ? req1_operand_a : req0_operand_a;
                operand_b  <= grant ? req1_operand_b : req0_operand_b;
            end else if (state == LOAD) begin
                state         <= IDLE;
                load_en       <= 1'b0;
                write_pointer <= write_pointer + AW'(1);
            end

            if (rd_fire) begin
                read_pointer <= read_pointer + AW'(1);
            end

            if (commit && !rd_fire) begin
                count <= count + (AW+1)'(1);
            end else if (!commit && rd_fire) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_reg_sequencer.sv
// tb/tb_instr_reg_sequencer.sv - randomized and directed bench for instr_reg_sequencer against a queue model
module tb_instr_reg_sequencer;
    import instr_reg_sequencer_pkg::*;

    logic clk, reset_n, flush;
    logic req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_opcode, req1_opcode, opcode;
    logic signed [31:0] req0_operand_a, req0_operand_b, req1_operand_a, req1_operand_b;
    logic signed [31:0] operand_a, operand_b;
    logic load_en, rd_valid, rd_ready, full, empty;
    logic [4:0] write_pointer, read_pointer;
    logic [5:0] count;
    instruction_t instruction_word, rd_word;

    instr_reg_sequencer dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_operand_a(req0_operand_a), .req0_operand_b(req0_operand_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_operand_a(req1_operand_a), .req1_operand_b(req1_operand_b),
        .load_en(load_en), .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
        .write_pointer(write_pointer), .read_pointer(read_pointer),
        .instruction_word(instruction_word), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_word(rd_word), .count(count), .full(full), .empty(empty)
    );

    // The instruction register itself lives in the environment.
    instruction_t regs [32];
    always @(posedge clk) if (load_en) regs[write_pointer] <= {opcode, operand_a, operand_b};
    assign instruction_word = regs[read_pointer];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    int vectors = 0;
    int miscompares = 0;

    instruction_t q[$];
    instruction_t infl;
    bit busy, lg, e_r0, e_r1;
    int mwp, mrp;

    task automatic model_reset();
        q.delete();
        busy = 0;
        lg   = 1;
        mwp  = 0;
        mrp  = 0;
    endtask

    task automatic predict();
        e_r0 = !flush && !busy && q.size() < 32 && req0_valid && (!req1_valid || lg);
        e_r1 = !flush && !busy && q.size() < 32 && req1_valid && (!req0_valid || !lg);
    endtask

    task automatic drive(input bit v0, input bit v1, input bit rdy, input bit fl);
        @(negedge clk);
        req0_valid = v0; req1_valid = v1; rd_ready = rdy; flush = fl;
        req0_opcode = 4'($urandom); req0_operand_a = $urandom; req0_operand_b = $urandom;
        req1_opcode = 4'($urandom); req1_operand_a = $urandom; req1_operand_b = $urandom;
        #1;
        predict();
    endtask

    task automatic advance();
        if (flush) begin
            q.delete();
            busy = 0;
            mwp = 0;
            mrp = 0;
        end else begin
            if (rd_ready && q.size() > 0) begin
                void'(q.pop_front());
                mrp = (mrp + 1) % 32;
            end
            if (busy) begin
                q.push_back(infl);
                mwp = (mwp + 1) % 32;
                busy = 0;
            end
            if (e_r0) begin
                busy = 1; infl = {req0_opcode, req0_operand_a, req0_operand_b}; lg = 0;
            end else if (e_r1) begin
                busy = 1; infl = {req1_opcode, req1_operand_a, req1_operand_b}; lg = 1;
            end
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 0; flush = 0; req0_valid = 0; req1_valid = 0; rd_ready = 0;
        model_reset();
        #2;
        reset_n = 1;
    endtask

    task automatic test_reset();
        reset_n = 0; flush = 0; req0_valid = 0; req1_valid = 0; rd_ready = 0;
        model_reset();
        repeat (2) @(negedge clk);
        vectors++; if (load_en !== 1'b0) begin miscompares++; $display("FAIL reset_load_en got=%b exp=0", load_en); end
        vectors++; if (count !== 6'd0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", count); end
        vectors++; if ({empty, full, rd_valid} !== 3'b100) begin miscompares++; $display("FAIL reset_flags got=%b exp=100", {empty, full, rd_valid}); end
        vectors++; if ({write_pointer, read_pointer} !== 10'd0) begin miscompares++; $display("FAIL reset_pointers got=%0d/%0d exp=0/0", write_pointer, read_pointer); end
        vectors++; if ({opcode, operand_a, operand_b} !== 68'd0) begin miscompares++; $display("FAIL reset_fields got=%h exp=0", {opcode, operand_a, operand_b}); end
        reset_n = 1;
    endtask

    task automatic test_single();
        instruction_t exp_w;
        exp_w = {4'd1, 32'sd5, 32'sd3};
        drive(1, 0, 0, 0);
        req0_opcode = 4'd1; req0_operand_a = 5; req0_operand_b = 3;
        vectors++; if ({req0_ready, req1_ready} !== 2'b10) begin miscompares++; $display("FAIL single_ready got=%b exp=10", {req0_ready, req1_ready}); end
        advance();
        drive(0, 0, 0, 0);
        vectors++; if ({load_en, write_pointer} !== 6'b1_00000) begin miscompares++; $display("FAIL single_load got=%b/%0d exp=1/0", load_en, write_pointer); end
        vectors++; if (req0_ready !== 1'b0) begin miscompares++; $display("FAIL single_ready_drop got=%b exp=0", req0_ready); end
        advance();
        drive(0, 0, 0, 0);
        vectors++; if ({load_en, rd_valid, count} !== {2'b01, 6'd1}) begin miscompares++; $display("FAIL single_commit got=%b/%b/%0d exp=0/1/1", load_en, rd_valid, count); end
        vectors++; if (rd_word !== exp_w) begin miscompares++; $display("FAIL single_word got=%h exp=%h", rd_word, exp_w); end
        advance();
        drive(0, 0, 1, 0);
        advance();
        drive(0, 0, 0, 0);
        vectors++; if ({count, empty, read_pointer} !== {6'd0, 1'b1, 5'd1}) begin miscompares++; $display("FAIL single_drain got=%0d/%b/%0d exp=0/1/1", count, empty, read_pointer); end
        advance();
    endtask

    task automatic test_fairness();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(1, 1, 0, 0);
            vectors++; if ({req0_ready, req1_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL fair_grant k=%0d got=%b exp=%s", k, {req0_ready, req1_ready}, (k % 2 == 0) ? "10" : "01"); end
            advance();
            drive(1, 1, 0, 0);
            vectors++; if ({load_en, req0_ready, req1_ready, write_pointer} !== {3'b100, 5'(k)}) begin miscompares++; $display("FAIL fair_load k=%0d got=%b/%0d exp=100/%0d", k, {load_en, req0_ready, req1_ready}, write_pointer, k); end
            vectors++; if (opcode !== infl.opcode) begin miscompares++; $display("FAIL fair_opcode k=%0d got=%h exp=%h", k, opcode, infl.opcode); end
            advance();
        end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int k = 0; k < 32; k++) begin
            drive(1, 0, 0, 0);
            advance();
            drive(0, 0, 0, 0);
            advance();
        end
        drive(1, 0, 0, 0);
        vectors++; if ({full, count, req0_ready} !== {1'b1, 6'd32, 1'b0}) begin miscompares++; $display("FAIL full_state got=%b/%0d/%b exp=1/32/0", full, count, req0_ready); end
        advance();
        drive(1, 0, 1, 0);
        vectors++; if (rd_word !== q[0]) begin miscompares++; $display("FAIL full_head got=%h exp=%h", rd_word, q[0]); end
        vectors++; if (req0_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready_on_read got=%b exp=0", req0_ready); end
        advance();
        drive(1, 0, 0, 0);
        vectors++; if ({count, read_pointer, req0_ready} !== {6'd31, 5'd1, 1'b1}) begin miscompares++; $display("FAIL full_after_read got=%0d/%0d/%b exp=31/1/1", count, read_pointer, req0_ready); end
        advance();
        drive(0, 0, 0, 0);
        vectors++; if ({load_en, write_pointer} !== 6'b1_00000) begin miscompares++; $display("FAIL full_wrap_write got=%b/%0d exp=1/0", load_en, write_pointer); end
        advance();
        drive(0, 0, 0, 0);
        vectors++; if ({full, count} !== {1'b1, 6'd32}) begin miscompares++; $display("FAIL full_refill got=%b/%0d exp=1/32", full, count); end
        advance();
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 0, 0);
            advance();
            drive(0, 0, 0, 0);
            advance();
        end
        drive(0, 1, 0, 0);
        advance();
        drive(0, 0, 1, 0);
        vectors++; if ({load_en, count} !== {1'b1, 6'd3}) begin miscompares++; $display("FAIL simul_pre got=%b/%0d exp=1/3", load_en, count); end
        advance();
        drive(0, 0, 0, 0);
        vectors++; if ({count, write_pointer, read_pointer} !== {6'd3, 5'd4, 5'd1}) begin miscompares++; $display("FAIL simul_post got=%0d/%0d/%0d exp=3/4/1", count, write_pointer, read_pointer); end
        advance();
    endtask

    task automatic test_flush_load();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            drive(1, 0, 0, 0);
            advance();
            drive(0, 0, 0, 0);
            advance();
        end
        drive(1, 0, 0, 0);
        advance();
        drive(1, 0, 1, 1);
        vectors++; if ({load_en, count, req0_ready} !== {1'b1, 6'd2, 1'b0}) begin miscompares++; $display("FAIL flush_during got=%b/%0d/%b exp=1/2/0", load_en, count, req0_ready); end
        advance();
        drive(0, 0, 0, 0);
        vectors++; if ({count, empty, rd_valid, load_en} !== {6'd0, 3'b100}) begin miscompares++; $display("FAIL flush_after got=%0d/%b/%b/%b exp=0/1/0/0", count, empty, rd_valid, load_en); end
        vectors++; if ({write_pointer, read_pointer} !== 10'd0) begin miscompares++; $display("FAIL flush_pointers got=%0d/%0d exp=0/0", write_pointer, read_pointer); end
        advance();
        drive(1, 0, 0, 0);
        advance();
        drive(0, 0, 0, 0);
        vectors++; if ({load_en, write_pointer} !== 6'b1_00000) begin miscompares++; $display("FAIL flush_next_write got=%b/%0d exp=1/0", load_en, write_pointer); end
        advance();
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1, 0, 0, 0);
        advance();
        drive(0, 0, 0, 0);
        vectors++; if (load_en !== 1'b1) begin miscompares++; $display("FAIL areset_pre got=%b exp=1", load_en); end
        #1;
        reset_n = 0;
        model_reset();
        #1;
        vectors++; if ({load_en, count, write_pointer, read_pointer} !== 17'd0) begin miscompares++; $display("FAIL areset_regs got=%b/%0d/%0d/%0d exp=0/0/0/0", load_en, count, write_pointer, read_pointer); end
        vectors++; if ({empty, full, opcode} !== {2'b10, 4'd0}) begin miscompares++; $display("FAIL areset_flags got=%b/%b/%h exp=1/0/0", empty, full, opcode); end
        #1;
        reset_n = 1;
    endtask

    task automatic test_random();
        int rdp;
        for (int i = 0; i < 1500; i++) begin
            rdp = (i < 700) ? 15 : 60;
            drive($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 70,
                  $urandom_range(0, 99) < rdp, $urandom_range(0, 99) < 2);
            vectors++; if ({req0_ready, req1_ready} !== {e_r0, e_r1}) begin miscompares++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, {req0_ready, req1_ready}, {e_r0, e_r1}); end
            vectors++; if (load_en !== busy) begin miscompares++; $display("FAIL rnd_load_en cyc=%0d got=%b exp=%b", i, load_en, busy); end
            vectors++; if ({write_pointer, read_pointer} !== {5'(mwp), 5'(mrp)}) begin miscompares++; $display("FAIL rnd_pointers cyc=%0d got=%0d/%0d exp=%0d/%0d", i, write_pointer, read_pointer, mwp, mrp); end
            vectors++; if (count !== 6'(q.size())) begin miscompares++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, count, q.size()); end
            vectors++; if ({full, empty, rd_valid} !== {q.size() == 32, q.size() == 0, q.size() != 0}) begin miscompares++; $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", i, {full, empty, rd_valid}, {q.size() == 32, q.size() == 0, q.size() != 0}); end
            if (busy) begin
                vectors++; if ({opcode, operand_a, operand_b} !== infl) begin miscompares++; $display("FAIL rnd_fields cyc=%0d got=%h exp=%h", i, {opcode, operand_a, operand_b}, infl); end
            end
            if (q.size() != 0) begin
                vectors++; if (rd_word !== q[0]) begin miscompares++; $display("FAIL rnd_word cyc=%0d got=%h exp=%h", i, rd_word, q[0]); end
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_full_wrap();
        test_simultaneous();
        test_flush_load();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_reg_sequencer.md
Name: instr_reg_sequencer

Overview:
Controller in front of the 32-entry instruction register. It round-robin arbitrates two requesters that submit opcode/operand pairs over valid/ready handshakes. It drives the register's load_en, write_pointer and fields, and manages write_pointer/read_pointer as a circular queue. It presents stored instruction words to a single consumer through a valid/ready read port.

Parameters:
DEPTH, 32, number of instruction register entries (power of 2).
AW, 5, pointer width, log2(DEPTH).
OPW, 4, opcode width.
DW, 32, operand width (signed).

Ports:
clk  input  1  clock, all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
flush  input  1  synchronous clear of queue state
req0_valid  input  1  requester 0 has an instruction
req0_ready  output  1  requester 0 accepted this cycle
req0_opcode  input  OPW  requester 0 opcode
req0_operand_a  input  DW  requester 0 operand a
req0_operand_b  input  DW  requester 0 operand b
req1_valid, req1_ready, req1_opcode, req1_operand_a, req1_operand_b  as requester 0
load_en  output  1  write strobe to instruction register
opcode  output  OPW  registered opcode to register
operand_a  output  DW  registered operand a
operand_b  output  DW  registered operand b
write_pointer  output  AW  entry being written
read_pointer  output  AW  entry presented on the read port
instruction_word  input  instruction_t  combinational read data from register
rd_valid  output  1  count != 0
rd_ready  input  1  consumer accepts the current word
rd_word  output  instruction_t  passthrough of instruction_word
count  output  AW+1  committed entries, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0

Behaviour:
- Reset (asynchronous): state IDLE; load_en, opcode, operands, write_pointer, read_pointer, count all 0; full=0, empty=1; last_grant=1, so req0 wins the first tie.
- FSM states: IDLE and LOAD.
- IDLE:
  - grant = the single valid requester.
  - If both are valid, grant goes to the requester not equal to last_grant.
  - reqN_ready = (state==IDLE) && grant==N && !full. It is combinational and never asserted to both requesters.
  - Handshake on valid&&ready at an edge: register the granted opcode/operands, load_en<=1, last_grant<=N, go to LOAD.
- LOAD (exactly one cycle):
  - load_en=1, so the register captures at the next edge.
  - At that edge: load_en<=0, write_pointer<=write_pointer+1 (wraps DEPTH-1 -> 0), count increments, return to IDLE.
- Timing: accept at edge N, load_en high N..N+1, data committed and rd_valid high after edge N+1. Peak throughput is one instruction per 2 cycles.
- Requester fields may change freely when ready=0; only the values at the handshake edge are used.
- Read port:
  - rd_word = instruction_word; read_pointer is driven from the internal rp.
  - On rd_valid&&rd_ready: read_pointer increments with wrap and count decrements.
  - rd_ready while empty is ignored.
- Simultaneous LOAD commit and read in the same edge: count unchanged, both pointers advance.
- Full: no ready is asserted. A pending request waits with valid held and is accepted in the cycle after a read frees a slot.
- flush (synchronous):
  - Pointers and count go to 0, state goes to IDLE, load_en<=0. last_grant is kept.
  - In LOAD, the in-flight write still hits the register at that edge but is discarded (not counted).
  - flush has priority over handshakes and reads in the same cycle; no ready is asserted while flush=1.
- reset_n low mid-LOAD: load_en drops immediately (asynchronous).
- The block never inspects or computes results; it only passes opcode and operands through.

Test Plan:
- Single request: reset, req0 sends ADD a=5 b=3 -> req0_ready 1 cycle; load_en high for 1 cycle with write_pointer=0; next cycle rd_valid=1, rd_word opcode ADD, operands 5/3, count=1.
- Fairness: both requesters hold valid for 6 accepts -> grants alternate 0,1,0,1,0,1; write_pointer values 0..5; a load_en gap between every pair of writes.
- Full/wrap: 32 writes with rd_ready=0 -> full=1 and req ready stays low. One read -> count 31, the held request is accepted and written at write_pointer=0 (wrap). read_pointer=1.
- Simultaneous: count=3, a commit coincides with a read -> count stays 3 and both pointers increment.
- Flush mid-LOAD: flush asserted during LOAD with count=2 -> count=0, empty=1, pointers 0, rd_valid=0. The next accept writes entry 0.
- Async reset mid-LOAD: reset_n low between edges -> load_en=0 immediately, all outputs at reset values.
